// File: rtl/breakout_pkg.sv
// Shared constants and types for the Breakout scene renderer.
// Screen geometry, brick layout, object sizes and the colour palette.
package breakout_pkg;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int COLS         = 10;
  localparam int ROWS         = 6;
  localparam int NBRICK       = ROWS * COLS;
  localparam int BRICK_W_LOG2 = 6;
  localparam int BRICK_H_LOG2 = 4;
  localparam int BRICK_GAP    = 2;
  localparam int BRICK_X0     = 0;
  localparam int BRICK_Y0     = 64;
  localparam int PADDLE_Y     = 448;
  localparam int PADDLE_H     = 8;
  localparam int PADDLE_W     = 64;
  localparam int BALL_SIZE    = 8;
  localparam int WALL_T       = 8;
  localparam int PADDLE_X_RST = 288;

  typedef logic [23:0] rgb_t;

  localparam rgb_t WHITE    = 24'hFFFFFF;
  localparam rgb_t CYAN     = 24'h00FFFF;
  localparam rgb_t GREY     = 24'h808080;
  localparam rgb_t BLACK    = 24'h000000;
  localparam rgb_t DARK_RED = 24'h400000;

  // Entry 0 (rightmost) is the top brick row.
  localparam logic [ROWS-1:0][23:0] ROW_COLOUR = {
    24'hFF00FF, 24'h0080FF, 24'h00FF00, 24'hFFFF00, 24'hFF8000, 24'hFF0000
  };

  typedef struct packed {
    logic       in_cell;
    logic [2:0] row;
    logic [5:0] idx;
  } cell_t;
endpackage

// File: rtl/breakout_brick_lookup.sv
// Maps a pixel coordinate to its brick cell: inside-brick flag, row and bit index.
// Purely combinational; registered by the renderer's first pipeline stage.
module brick_lookup
  import breakout_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output cell_t      o_cell
);
  logic [10:0]              w_dx, w_dy;
  logic [10-BRICK_W_LOG2:0] w_col;
  logic [10-BRICK_H_LOG2:0] w_row;
  logic                     w_x_brick, w_y_brick;

  // Coordinates left of / above the field wrap to huge offsets, so the
  // col/row range checks also cover the x>=X0 and y>=Y0 conditions.
  assign w_dx  = {1'b0, i_x} - 11'(BRICK_X0);
  assign w_dy  = {1'b0, i_y} - 11'(BRICK_Y0);
  assign w_col = w_dx[10:BRICK_W_LOG2];
  assign w_row = w_dy[10:BRICK_H_LOG2];

  assign w_x_brick = w_dx[BRICK_W_LOG2-1:0] < BRICK_W_LOG2'(2**BRICK_W_LOG2 - BRICK_GAP);
  assign w_y_brick = w_dy[BRICK_H_LOG2-1:0] < BRICK_H_LOG2'(2**BRICK_H_LOG2 - BRICK_GAP);

  assign o_cell.in_cell = (w_col < ($bits(w_col))'(COLS)) && (w_row < ($bits(w_row))'(ROWS))
                          && w_x_brick && w_y_brick;
  assign o_cell.row     = w_row[2:0];
  assign o_cell.idx     = 6'(w_row[2:0]) * 6'(COLS) + 6'(w_col[3:0]);
endmodule

// File: rtl/breakout_renderer.sv
// Breakout pixel colour generator: per-frame game-state snapshot on VSYNC fall,
// two-stage pixel pipeline with sync/blank delayed to match.
module breakout_renderer
  import breakout_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        i_next_x,
  input  logic [9:0]        i_next_y,
  input  logic              i_active,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic [9:0]        i_paddle_x,
  input  logic [9:0]        i_ball_x,
  input  logic [9:0]        i_ball_y,
  input  logic [NBRICK-1:0] i_brick_alive,
  input  logic              i_game_over,
  output logic [7:0]        o_vga_r,
  output logic [7:0]        o_vga_g,
  output logic [7:0]        o_vga_b,
  output logic              o_vga_hs,
  output logic              o_vga_vs,
  output logic              o_vga_blank_n,
  output logic              o_frame_start
);
  logic [9:0]        r_sh_paddle_x, r_sh_ball_x, r_sh_ball_y;
  logic [NBRICK-1:0] r_sh_alive;
  logic              r_sh_game_over;
  logic              r_vs_prev, r_frame_start;
  logic [1:0]        r_act_pipe, r_hs_pipe, r_vs_pipe;
  logic              r_s1_ball, r_s1_paddle, r_s1_wall;
  cell_t             r_s1_cell;
  rgb_t              r_rgb;

  logic [10:0] w_x, w_y, w_bx, w_by, w_px;
  logic        w_vs_fall, w_in_ball, w_in_paddle, w_in_wall, w_brick;
  cell_t       w_cell;
  rgb_t        w_rgb;

  assign w_vs_fall = r_vs_prev & ~i_vs;

  assign w_x  = {1'b0, i_next_x};
  assign w_y  = {1'b0, i_next_y};
  assign w_bx = {1'b0, r_sh_ball_x};
  assign w_by = {1'b0, r_sh_ball_y};
  assign w_px = {1'b0, r_sh_paddle_x};

  assign w_in_ball   = (w_x >= w_bx) && (w_x < w_bx + 11'(BALL_SIZE))
                    && (w_y >= w_by) && (w_y < w_by + 11'(BALL_SIZE));
  assign w_in_paddle = (w_x >= w_px) && (w_x < w_px + 11'(PADDLE_W))
                    && (w_y >= 11'(PADDLE_Y)) && (w_y < 11'(PADDLE_Y + PADDLE_H));
  assign w_in_wall   = (w_x < 11'(WALL_T)) || (w_x >= 11'(SCREEN_W - WALL_T)) || (w_y < 11'(WALL_T));

  brick_lookup u_brick_lookup (
    .i_x    (i_next_x),
    .i_y    (i_next_y),
    .o_cell (w_cell)
  );

  assign w_brick = r_s1_cell.in_cell && r_sh_alive[r_s1_cell.idx];

  always_comb begin
    w_rgb = r_sh_game_over ? DARK_RED : BLACK;
    if (r_s1_wall)   w_rgb = GREY;
    if (w_brick)     w_rgb = ROW_COLOUR[r_s1_cell.row];
    if (r_s1_paddle) w_rgb = CYAN;
    if (r_s1_ball)   w_rgb = WHITE;
    if (!r_act_pipe[0]) w_rgb = BLACK;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sh_paddle_x  <= 10'(PADDLE_X_RST);
      r_sh_ball_x    <= '0;
      r_sh_ball_y    <= '0;
      r_sh_alive     <= '0;
      r_sh_game_over <= 1'b0;
      r_vs_prev      <= 1'b1;
      r_frame_start  <= 1'b0;
      r_act_pipe     <= 2'b00;
      r_hs_pipe      <= 2'b11;
      r_vs_pipe      <= 2'b11;
      r_s1_ball      <= 1'b0;
      r_s1_paddle    <= 1'b0;
      r_s1_wall      <= 1'b0;
      r_s1_cell      <= '0;
      r_rgb          <= BLACK;
    end else begin
      r_vs_prev     <= i_vs;
      r_frame_start <= w_vs_fall;
      if (w_vs_fall) begin
        r_sh_paddle_x  <= i_paddle_x;
        r_sh_ball_x    <= i_ball_x;
        r_sh_ball_y    <= i_ball_y;
        r_sh_alive     <= i_brick_alive;
        r_sh_game_over <= i_game_over;
      end
      r_act_pipe  <= {r_act_pipe[0], i_active};
      r_hs_pipe   <= {r_hs_pipe[0], i_hs};
      r_vs_pipe   <= {r_vs_pipe[0], i_vs};
      r_s1_ball   <= w_in_ball;
      r_s1_paddle <= w_in_paddle;
      r_s1_wall   <= w_in_wall;
      r_s1_cell   <= w_cell;
      r_rgb       <= w_rgb;
    end
  end

  assign o_vga_r       = r_rgb[23:16];
  assign o_vga_g       = r_rgb[15:8];
  assign o_vga_b       = r_rgb[7:0];
  assign o_vga_hs      = r_hs_pipe[1];
  assign o_vga_vs      = r_vs_pipe[1];
  assign o_vga_blank_n = r_act_pipe[1];
  assign o_frame_start = r_frame_start;
endmodule

// File: tb/tb_breakout_renderer.sv
// Scoreboard bench for breakout_renderer: stimulus pushes hand-computed
// expectations tagged with their due cycle; a monitor pops and compares.
module tb_breakout_renderer;
  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  next_x, next_y, paddle_x, ball_x, ball_y;
  logic        active, hs_in, vs_in, game_over;
  logic [59:0] brick_alive;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start;

  localparam logic [23:0] C_WHITE = 24'hFFFFFF, C_CYAN = 24'h00FFFF, C_GREY = 24'h808080;
  localparam logic [23:0] C_BLACK = 24'h000000, C_DRED = 24'h400000;
  localparam logic [23:0] C_ROW0  = 24'hFF0000, C_ROW1 = 24'hFF8000;
  localparam logic [26:0] RST_OUT = {24'h0, 1'b0, 1'b1, 1'b1};

  breakout_renderer dut (
    .clock(clock), .reset(reset),
    .i_next_x(next_x), .i_next_y(next_y), .i_active(active), .i_hs(hs_in), .i_vs(vs_in),
    .i_paddle_x(paddle_x), .i_ball_x(ball_x), .i_ball_y(ball_y),
    .i_brick_alive(brick_alive), .i_game_over(game_over),
    .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
    .o_vga_hs(vga_hs), .o_vga_vs(vga_vs), .o_vga_blank_n(vga_blank_n),
    .o_frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    bit          is_fs;
    logic [26:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int dly, input bit is_fs, input logic [26:0] exp, input string name);
    sb_t e;
    e.due = cyc + dly; e.is_fs = is_fs; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  // Monitor: every output cycle, compare all entries due now.
  initial begin : monitor
    int          i;
    logic [26:0] act;
    forever begin
      @(posedge clock);
      #1;
      i = 0;
      while (i < sbq.size()) begin
        if (sbq[i].due == cyc) begin
          act = sbq[i].is_fs ? {26'h0, frame_start}
                             : {vga_r, vga_g, vga_b, vga_blank_n, vga_hs, vga_vs};
          n_chk++;
          if (act === sbq[i].exp) n_pass++;
          else $display("FAIL %s: got %h want %h (cycle %0d)", sbq[i].name, act, sbq[i].exp, cyc);
          sbq.delete(i);
        end else if (sbq[i].due < cyc) begin
          n_chk++;
          $display("FAIL %s: never sampled, due cycle %0d", sbq[i].name, sbq[i].due);
          sbq.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic pix(input int x, input int y, input bit act, input bit hs,
                     input logic [23:0] rgb, input string name);
    @(negedge clock);
    next_x = 10'(x); next_y = 10'(y); active = act; hs_in = hs; vs_in = 1'b1;
    push(2, 1'b0, {rgb, act, hs, 1'b1}, name);
  endtask

  task automatic vfall();
    @(negedge clock);
    active = 1'b0; vs_in = 1'b0;
    push(1, 1'b1, 27'd1, "fs_pulse");
    @(negedge clock);
    vs_in = 1'b1;
    push(1, 1'b1, 27'd0, "fs_single");
  endtask

  initial begin
    reset = 1'b1; next_x = '0; next_y = '0; active = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    paddle_x = 10'd300; ball_x = 10'd100; ball_y = 10'd200;
    brick_alive = '0; brick_alive[0] = 1'b1; brick_alive[11] = 1'b1; game_over = 1'b0;

    // Reset state
    repeat (3) begin
      @(negedge clock);
      push(1, 1'b0, RST_OUT, "reset_out");
      push(1, 1'b1, 27'd0, "reset_fs");
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      push(1, 1'b1, 27'd0, "fs_idle");
    end

    vfall();
    // Ball edges
    pix(107, 200, 1, 1, C_WHITE, "ball_in");
    pix(108, 200, 1, 1, C_BLACK, "ball_right");
    pix(100, 207, 1, 1, C_WHITE, "ball_corner");
    pix( 99, 207, 1, 1, C_BLACK, "ball_left");
    pix(100, 208, 1, 1, C_BLACK, "ball_below");
    // Bricks, gaps, walls
    pix( 64,  80, 1, 1, C_ROW1,  "brick_r1c1");
    pix(126,  80, 1, 1, C_BLACK, "brick_xgap");
    pix(125,  93, 1, 1, C_ROW1,  "brick_last_px");
    pix( 64,  94, 1, 1, C_BLACK, "brick_ygap");
    pix(128,  64, 1, 1, C_BLACK, "brick_dead");
    pix(  0,  64, 1, 1, C_ROW0,  "brick_over_wall");
    pix(  3, 300, 1, 1, C_GREY,  "wall_left");
    pix(632, 300, 1, 1, C_GREY,  "wall_right");
    pix(631, 300, 1, 1, C_BLACK, "wall_right_in");
    pix(300,   7, 1, 1, C_GREY,  "wall_top");
    // Paddle
    pix(300, 450, 1, 1, C_CYAN,  "paddle_in");
    pix(363, 455, 1, 1, C_CYAN,  "paddle_corner");
    pix(364, 450, 1, 1, C_BLACK, "paddle_right");
    pix(300, 456, 1, 1, C_BLACK, "paddle_below");
    pix(200, 300, 1, 0, C_BLACK, "hsync_delay");

    // Mid-frame changes are invisible until the next VSYNC fall
    ball_x = 10'd400; brick_alive[11] = 1'b0; game_over = 1'b1;
    pix(107, 200, 1, 1, C_WHITE, "hold_ball");
    pix(400, 200, 1, 1, C_BLACK, "hold_newball");
    pix( 64,  80, 1, 1, C_ROW1,  "hold_brick");
    pix(108, 200, 1, 1, C_BLACK, "hold_bg");
    vfall();
    pix(400, 200, 1, 1, C_WHITE, "new_ball");
    pix(107, 200, 1, 1, C_DRED,  "old_ball_gone");
    pix( 64,  80, 1, 1, C_DRED,  "brick_cleared");
    pix(  0,  64, 1, 1, C_ROW0,  "brick0_kept");

    // Ball over paddle, blanking
    game_over = 1'b0; ball_x = 10'd296; ball_y = 10'd446;
    vfall();
    pix(300, 450, 1, 1, C_WHITE, "ball_over_paddle");
    pix(310, 450, 1, 1, C_CYAN,  "paddle_beside_ball");
    pix(300, 450, 0, 1, C_BLACK, "blank_masks");

    // Reset mid-line
    paddle_x = 10'd100; ball_x = 10'd500; ball_y = 10'd300; brick_alive[11] = 1'b1;
    @(negedge clock);
    next_x = 10'd300; next_y = 10'd450; active = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    push(1, 1'b0, RST_OUT, "mid_reset_out");
    @(negedge clock);
    reset = 1'b0;
    push(1, 1'b0, RST_OUT, "mid_reset_flush");
    push(2, 1'b0, {C_CYAN, 1'b1, 1'b1, 1'b1}, "rst_paddle_288");
    pix(  3,   3, 1, 1, C_WHITE, "rst_ball_00");
    pix( 64,  80, 1, 1, C_BLACK, "rst_bricks_off");
    pix(100, 450, 1, 1, C_BLACK, "rst_live_paddle_off");
    pix(288, 450, 1, 1, C_CYAN,  "rst_paddle_left");
    pix(287, 450, 1, 1, C_BLACK, "rst_paddle_edge");
    vfall();
    pix(100, 450, 1, 1, C_CYAN,  "reload_paddle");
    pix(300, 450, 1, 1, C_BLACK, "reload_old_paddle");
    pix( 64,  80, 1, 1, C_ROW1,  "reload_brick");
    pix(503, 307, 1, 1, C_WHITE, "reload_ball");

    @(negedge clock);
    active = 1'b0;
    repeat (4) @(negedge clock);
    if (sbq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
